blink_sequencer: RTL and testbench
==================================

Name: blink_sequencer

Overview:
- Multi-channel LED blinker with a built-in frequency schedule; parametrised successor of the single-LED blinker and its hard-coded frequency-change counter.
- Each channel toggles its LED with a per-channel half-period and switches between profile A and profile B after a dwell time.
- Switching is one-shot (A then B forever) or looping (A, B, A, ...).
- Sits at top level between CLK_25MHZ/RSTN and the board LEDs. Half-periods come from constants or from the serial control block.

Parameters:
- NUM_CH, 2, number of LED channels (1..8)
- CNT_W, 32, width of half-period values and of the per-channel counters
- DWELL_W, 32, width of the dwell counter
- DWELL, 25000000, cycles spent in each profile before switching (must be >=1)

Ports:
- CLK_25MHZ  in  1  system clock
- RSTN  in  1  synchronous active-high reset
- en  in  1  level; 1 runs the sequencer, 0 returns it to IDLE
- loop_mode  in  1  0 = one-shot A->B, 1 = alternate A<->B; sampled only on the IDLE->PH_A transition
- hp_a  in  NUM_CH*CNT_W  profile-A half-periods in cycles; channel i = bits [i*CNT_W +: CNT_W]
- hp_b  in  NUM_CH*CNT_W  profile-B half-periods, same packing
- led_o  out  NUM_CH  LED outputs
- phase_o  out  1  0 = profile A active, 1 = profile B active
- step_o  out  1  one-cycle pulse on every profile switch

Behaviour:
- Reset: RSTN high at a rising edge sets state IDLE and clears dwell_cnt, all ch_cnt, led_o, phase_o, step_o and the latched loop mode. Reset takes priority over everything, including mid-dwell and mid-half-period.
- FSM states: IDLE, PH_A, PH_B.
- IDLE:
  - led_o = 0, counters held at 0.
  - On en=1, next cycle the state is PH_A, dwell_cnt = 0 and loop_mode is latched.
  - Led toggling starts in that PH_A cycle.
- PH_A / PH_B:
  - dwell_cnt increments every cycle.
  - When dwell_cnt == DWELL-1: dwell_cnt clears and step_o = 1 for that next cycle.
  - Next state from PH_A is PH_B.
  - Next state from PH_B is PH_A if loop mode is latched at 1; otherwise the block stays in PH_B, never pulses step_o again and dwell_cnt freezes at 0.
- en=0 in any running state: the next cycle is IDLE and led_o clears. Re-asserting en restarts from PH_A.
- phase_o = 1 exactly when the state is PH_B, and is registered alongside the state.
- Per-channel divider; hp is the active profile value (hp_a in PH_A, hp_b in PH_B), read combinationally every cycle:
  - hp == 0: led forced 0, ch_cnt held at 0.
  - ch_cnt >= hp-1: led toggles, ch_cnt clears. Using >= means a shrinking hp never overruns the counter.
  - Otherwise ch_cnt increments.
  - Arithmetic is unsigned CNT_W-bit. hp = 2^CNT_W-1 must work without wrap.
- Profile switch: all ch_cnt clear in the cycle step_o is asserted. led levels are kept (no glitch pulse) unless the optional feature is enabled.
- hp = 1 gives a toggle every cycle, so the LED period is 2 cycles.
- Simultaneous events: a toggle condition and a profile switch in the same cycle both take effect; the toggle applies and ch_cnt ends at 0.

Optional Feature:
- Macro: BLINK_PHASE_ALIGN_EN.
- Defined: on every profile switch (the step_o cycle) all led_o bits are forced to 0 and ch_cnt cleared, so all channels restart in phase. A coincident toggle is overridden.
- Undefined: led levels are preserved across the switch as described above.

Test Plan:
- Reset: NUM_CH=2, CNT_W=8, DWELL=10. Hold RSTN 3 cycles with en=1 -> led_o=00, phase_o=0, step_o=0. Release -> led toggling begins within 1 cycle of PH_A entry.
- One-shot: hp_a={4,2}, hp_b={1,3}, loop_mode=0, en=1 -> ch0 toggles every 2 cycles and ch1 every 4 during the first 10 cycles. Then step_o pulses once, phase_o=1, and ch0 toggles every 3, ch1 every cycle. There is no further step_o over 100 cycles.
- Loop: same stimulus with loop_mode=1 -> step_o every 10 cycles, phase_o alternates 0,1,0,1; 5 pulses seen in 50 cycles.
- Zero/max: hp_a ch0=0 -> led_o[0] stays 0. hp_a ch1=255 -> toggles every 255 cycles with no wrap (use DWELL=600).
- Mid-run abort: drop en during PH_B mid half-period -> next cycle IDLE, led_o=00. Re-raise en -> phase_o=0, full 10-cycle dwell before step_o. Repeat with RSTN instead of en; the result is identical.
- With BLINK_PHASE_ALIGN_EN: at the step_o cycle both led_o bits are 0 regardless of prior level. Without the macro, levels are unchanged at that cycle.

Source files
------------

// File: rtl/blink_sequencer.sv
// blink_sequencer: multi-channel LED blinker with a two-profile frequency schedule.
// Each channel divides the clock by a per-channel half-period taken from profile A
// or profile B. The active profile switches after DWELL cycles, either once (A->B)
// or repeatedly (A<->B), depending on loop_mode latched when the block leaves IDLE.
// Optional feature macro: BLINK_PHASE_ALIGN_EN. When it is defined, every profile
// switch forces all LEDs low so that the channels restart in phase.
module blink_sequencer #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned DWELL_W = 32,
    parameter int unsigned DWELL   = 25000000
) (
    input  logic                    CLK_25MHZ,
    input  logic                    RSTN,       // synchronous, active-high
    input  logic                    en,
    input  logic                    loop_mode,
    input  logic [NUM_CH*CNT_W-1:0] hp_a,
    input  logic [NUM_CH*CNT_W-1:0] hp_b,
    output logic [NUM_CH-1:0]       led_o,
    output logic                    phase_o,
    output logic                    step_o
);

    typedef enum logic [1:0] {
        StIdle,
        StPhA,
        StPhB
    } state_e;

    localparam logic [DWELL_W-1:0] DwellLast = DWELL_W'(DWELL - 1);

    state_e               state_q, state_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 loop_q, loop_d;
    logic                 phase_q, phase_d;
    logic                 step_q, step_d;
    logic [NUM_CH-1:0]    led_q, led_d;
    logic [CNT_W-1:0]     cnt_q [NUM_CH];
    logic [CNT_W-1:0]     cnt_d [NUM_CH];
    logic [CNT_W-1:0]     hp_act [NUM_CH];
    logic                 switch_now;  // profile switch takes effect at the next edge
    logic                 run;         // dividers advance this cycle

    // Schedule FSM: state transitions, dwell counting and switch detection.
    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        loop_d     = loop_q;
        switch_now = 1'b0;
        unique case (state_q)
            StIdle: begin
                dwell_d = '0;
                if (en) begin
                    state_d = StPhA;
                    loop_d  = loop_mode;
                end
            end
            StPhA: begin
                if (!en) begin
                    state_d = StIdle;
                    dwell_d = '0;
                end else if (dwell_q == DwellLast) begin
                    state_d    = StPhB;
                    dwell_d    = '0;
                    switch_now = 1'b1;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            StPhB: begin
                if (!en) begin
                    state_d = StIdle;
                    dwell_d = '0;
                end else if (!loop_q) begin
                    // One-shot schedule parks in profile B for good.
                    dwell_d = '0;
                end else if (dwell_q == DwellLast) begin
                    state_d    = StPhA;
                    dwell_d    = '0;
                    switch_now = 1'b1;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                dwell_d = '0;
            end
        endcase
        step_d  = switch_now;
        phase_d = (state_d == StPhB);
    end

    // Select the half-period of the profile active in the current state.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hp_act[i] = (state_q == StPhB) ? hp_b[i*CNT_W +: CNT_W] : hp_a[i*CNT_W +: CNT_W];
        end
    end

    assign run = (state_q != StIdle) && en;

    // Per-channel half-period dividers.
    always_comb begin
        led_d = led_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!run || hp_act[i] == '0) begin
                led_d[i] = 1'b0;
                cnt_d[i] = '0;
            end else begin
                // >= keeps a counter that outgrew a shrinking half-period from overrunning.
                if (cnt_q[i] >= hp_act[i] - CNT_W'(1)) begin
                    led_d[i] = ~led_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                if (switch_now) begin
                    cnt_d[i] = '0;
`ifdef BLINK_PHASE_ALIGN_EN
                    led_d[i] = 1'b0;
`endif
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK_25MHZ) begin
        if (RSTN) begin
            state_q <= StIdle;
            dwell_q <= '0;
            loop_q  <= 1'b0;
            phase_q <= 1'b0;
            step_q  <= 1'b0;
            led_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            led_q   <= led_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign led_o   = led_q;
    assign phase_o = phase_q;
    assign step_o  = step_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer: a DWELL=10 instance for schedule behaviour
// and a DWELL=600 instance for the zero / maximum half-period checks.
module tb_blink_sequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        loop_mode;
    logic [15:0] hp_a;
    logic [15:0] hp_b;
    logic [1:0]  led;
    logic        phase;
    logic        step;

    logic        en_l;
    logic [15:0] hp_a_l;
    logic [15:0] hp_b_l;
    logic [1:0]  led_l;
    logic        phase_l;
    logic        step_l;

    int total;
    int bad;

    blink_sequencer #(
        .NUM_CH (2),
        .CNT_W  (8),
        .DWELL_W(16),
        .DWELL  (10)
    ) u_dut (
        .CLK_25MHZ(clk),
        .RSTN     (rst),
        .en       (en),
        .loop_mode(loop_mode),
        .hp_a     (hp_a),
        .hp_b     (hp_b),
        .led_o    (led),
        .phase_o  (phase),
        .step_o   (step)
    );

    blink_sequencer #(
        .NUM_CH (2),
        .CNT_W  (8),
        .DWELL_W(16),
        .DWELL  (600)
    ) u_dut_long (
        .CLK_25MHZ(clk),
        .RSTN     (rst),
        .en       (en_l),
        .loop_mode(1'b0),
        .hp_a     (hp_a_l),
        .hp_b     (hp_b_l),
        .led_o    (led_l),
        .phase_o  (phase_l),
        .step_o   (step_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        en   = 1'b0;
        en_l = 1'b0;
        rst  = 1'b0;
        step_clk();
        step_clk();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        en        = 1'b1;
        loop_mode = 1'b0;
        hp_a      = {8'd1, 8'd1};
        hp_b      = {8'd1, 8'd1};
        for (int c = 0; c < 3; c++) begin
            step_clk();
            total++;
            if ({step, phase, led} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hold c=%0d got=%b want=0000", c, {step, phase, led});
            end
        end
        rst = 1'b0;
        step_clk();
        total++;
        if ({step, phase, led} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_entry got=%b want=0000", {step, phase, led});
        end
        step_clk();
        total++;
        if ({step, phase, led} !== 4'b0011) begin
            bad++;
            $display("FAIL reset_first_toggle got=%b want=0011", {step, phase, led});
        end
    endtask

    task automatic test_one_shot();
        logic [3:0] want;
        int         j;
        logic       base0;
`ifdef BLINK_PHASE_ALIGN_EN
        base0 = 1'b0;
`else
        base0 = 1'b1;
`endif
        go_idle();
        hp_a      = {8'd4, 8'd2};
        hp_b      = {8'd1, 8'd3};
        loop_mode = 1'b0;
        en        = 1'b1;
        for (int k = 0; k < 110; k++) begin
            step_clk();
            if (k < 10) begin
                want = {1'b0, 1'b0, 1'((k / 4) % 2), 1'((k / 2) % 2)};
            end else begin
                j    = k - 10;
                want = {(k == 10), 1'b1, 1'(j % 2), base0 ^ 1'((j / 3) % 2)};
            end
            total++;
            if ({step, phase, led} !== want) begin
                bad++;
                $display("FAIL one_shot k=%0d got=%b want=%b", k, {step, phase, led}, want);
            end
        end
    endtask

    task automatic test_loop();
        int   steps;
        logic want_phase;
        logic want_step;
        go_idle();
        hp_a      = {8'd4, 8'd2};
        hp_b      = {8'd1, 8'd3};
        loop_mode = 1'b1;
        en        = 1'b1;
        steps     = 0;
        for (int k = 0; k <= 50; k++) begin
            step_clk();
            // Mode is latched on entry; later changes must be ignored.
            loop_mode  = 1'b0;
            want_phase = 1'((k / 10) % 2);
            want_step  = (k != 0) && (k % 10 == 0);
            if (step === 1'b1) steps++;
            total++;
            if ({step, phase} !== {want_step, want_phase}) begin
                bad++;
                $display("FAIL loop k=%0d got=%b want=%b", k, {step, phase},
                         {want_step, want_phase});
            end
        end
        total++;
        if (steps !== 5) begin
            bad++;
            $display("FAIL loop_count got=%0d want=5", steps);
        end
    endtask

    task automatic test_zero_max();
        logic [2:0] want;
        go_idle();
        hp_a_l = {8'd255, 8'd0};
        hp_b_l = 16'd0;
        en_l   = 1'b1;
        for (int k = 0; k < 600; k++) begin
            step_clk();
            want = {1'b0, 1'((k / 255) % 2), 1'b0};
            total++;
            if ({phase_l, led_l} !== want) begin
                bad++;
                $display("FAIL zero_max k=%0d got=%b want=%b", k, {phase_l, led_l}, want);
            end
        end
        en_l = 1'b0;
    endtask

    task automatic test_abort();
        logic [3:0] want;
        for (int m = 0; m < 2; m++) begin
            go_idle();
            hp_a      = {8'd4, 8'd2};
            hp_b      = {8'd1, 8'd3};
            loop_mode = 1'b0;
            en        = 1'b1;
            for (int k = 0; k < 15; k++) step_clk();
            total++;
            if (phase !== 1'b1) begin
                bad++;
                $display("FAIL abort_pre m=%0d got=%b want=1", m, phase);
            end
            if (m == 0) en = 1'b0;
            else rst = 1'b1;
            step_clk();
            total++;
            if ({step, phase, led} !== 4'b0000) begin
                bad++;
                $display("FAIL abort_idle m=%0d got=%b want=0000", m, {step, phase, led});
            end
            en  = 1'b1;
            rst = 1'b0;
            for (int k = 0; k <= 10; k++) begin
                step_clk();
                if (k < 10) want = {1'b0, 1'b0, 1'((k / 4) % 2), 1'((k / 2) % 2)};
                else want = {1'b1, 1'b1, 2'bxx};
                total++;
                if ((k < 10 && {step, phase, led} !== want) ||
                    (k == 10 && {step, phase} !== 2'b11)) begin
                    bad++;
                    $display("FAIL abort_restart m=%0d k=%0d got=%b want=%b", m, k,
                             {step, phase, led}, want);
                end
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        en        = 1'b0;
        en_l      = 1'b0;
        loop_mode = 1'b0;
        hp_a      = '0;
        hp_b      = '0;
        hp_a_l    = '0;
        hp_b_l    = '0;
        test_reset();
        test_one_shot();
        test_loop();
        test_zero_max();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
